// File: rtl/fb_host_write_ctrl_if.sv
// Host-side and framebuffer-write-port signals for fb_host_write_ctrl.
// The master is the host/timing side; the slave is the write controller.
interface fb_host_write_ctrl_if;
  logic [7:0]  host_data;
  logic        host_strobe;
  logic        blank;
  logic        host_busy;
  logic        overflow;
  logic [10:0] mem_addr;
  logic        mem_we;
  logic [1:0]  mem_data;

  modport master (
    output host_data, host_strobe, blank,
    input  host_busy, overflow, mem_addr, mem_we, mem_data
  );

  modport slave (
    input  host_data, host_strobe, blank,
    output host_busy, overflow, mem_addr, mem_we, mem_data
  );
endinterface

// File: rtl/fb_host_write_ctrl.sv
// Host command writer for the 40x30 2-bit framebuffer: strobe sync, command FIFO, blank-gated writes.
// Optional FBW_AUTOINC_EN: advance the cursor (raster order, wrapping) after each PIXEL write.
module fb_host_write_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int COLS       = 40,
  parameter int ROWS       = 30
) (
  input logic                 clk,
  input logic                 rst,
  fb_host_write_ctrl_if.slave bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);
  localparam logic [10:0]      LAST_ADDR = 11'(COLS * ROWS - 1);
  localparam logic [5:0]       X_MAX     = 6'(COLS - 1);
  localparam logic [4:0]       Y_MAX     = 5'(ROWS - 1);

  localparam logic [1:0] OP_SET_X = 2'b00;
  localparam logic [1:0] OP_SET_Y = 2'b01;
  localparam logic [1:0] OP_PIXEL = 2'b10;
  localparam logic [1:0] OP_FILL  = 2'b11;

  typedef enum logic [1:0] {IDLE, EXEC, FILL} state_t;

  state_t           state_q, state_d;
  logic [2:0]       sync_q, sync_d;
  logic [7:0]       fifo_q [FIFO_DEPTH];
  logic [7:0]       fifo_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             host_busy_q, host_busy_d;
  logic             overflow_q, overflow_d;
  logic [5:0]       x_q, x_d;
  logic [4:0]       y_q, y_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [10:0]      fill_cnt_q, fill_cnt_d;

  logic             strobe_rise;
  logic             fifo_full;
  logic             push;
  logic             pop;
  logic [7:0]       head;
  logic [10:0]      mem_addr_c;
  logic             mem_we_c;
  logic [1:0]       mem_data_c;

  // Cursor is clamped, so y*40+x always fits in 11 bits.
  function automatic logic [10:0] cell_addr(input logic [5:0] cx, input logic [4:0] cy);
    return ({6'd0, cy} << 5) + ({6'd0, cy} << 3) + {5'd0, cx};
  endfunction

  function automatic logic [5:0] clamp_x(input logic [5:0] arg);
    return (arg > X_MAX) ? X_MAX : arg;
  endfunction

  function automatic logic [4:0] clamp_y(input logic [5:0] arg);
    return (arg > {1'b0, Y_MAX}) ? Y_MAX : arg[4:0];
  endfunction

  assign strobe_rise = sync_q[1] & ~sync_q[2];
  assign fifo_full   = (cnt_q == CNT_FULL);
  assign push        = strobe_rise & ~fifo_full;
  assign head        = fifo_q[rd_ptr_q];

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    fill_cnt_d = fill_cnt_q;
    x_d        = x_q;
    y_d        = y_q;
    pop        = 1'b0;
    mem_addr_c = '0;
    mem_we_c   = 1'b0;
    mem_data_c = '0;

    case (state_q)
      IDLE: begin
        // Cursor moves touch no memory, so they may drain during active video.
        if ((cnt_q != '0) && (bus.blank || (head[7:6] == OP_SET_X) || (head[7:6] == OP_SET_Y))) begin
          pop     = 1'b1;
          cmd_d   = head;
          state_d = EXEC;
        end
      end
      EXEC: begin
        case (cmd_q[7:6])
          OP_SET_X: begin
            x_d     = clamp_x(cmd_q[5:0]);
            state_d = IDLE;
          end
          OP_SET_Y: begin
            y_d     = clamp_y(cmd_q[5:0]);
            state_d = IDLE;
          end
          OP_PIXEL: begin
            mem_addr_c = cell_addr(x_q, y_q);
            mem_data_c = cmd_q[1:0];
            if (bus.blank) begin
              mem_we_c = 1'b1;
              state_d  = IDLE;
`ifdef FBW_AUTOINC_EN
              if (x_q == X_MAX) begin
                x_d = '0;
                y_d = (y_q == Y_MAX) ? '0 : y_q + 5'd1;
              end else begin
                x_d = x_q + 6'd1;
              end
`endif
            end
          end
          OP_FILL: begin
            fill_cnt_d = '0;
            state_d    = FILL;
          end
          default: state_d = IDLE;
        endcase
      end
      FILL: begin
        mem_addr_c = fill_cnt_q;
        mem_data_c = cmd_q[1:0];
        if (bus.blank) begin
          mem_we_c = 1'b1;
          if (fill_cnt_q == LAST_ADDR) state_d = IDLE;
          else                         fill_cnt_d = fill_cnt_q + 11'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sync_d   = {sync_q[1:0], bus.host_strobe};
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      fifo_d[wr_ptr_q] = bus.host_data;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    cnt_d       = cnt_q + CNT_W'(push) - CNT_W'(pop);
    host_busy_d = (cnt_d == CNT_FULL);
    overflow_d  = overflow_q | (strobe_rise & fifo_full);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sync_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      host_busy_q <= 1'b0;
      overflow_q  <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      host_busy_q <= host_busy_d;
      overflow_q  <= overflow_d;
      x_q         <= x_d;
      y_q         <= y_d;
    end
    fifo_q     <= fifo_d;
    cmd_q      <= cmd_d;
    fill_cnt_q <= fill_cnt_d;
  end

  assign bus.host_busy = host_busy_q;
  assign bus.overflow  = overflow_q;
  assign bus.mem_addr  = mem_addr_c;
  assign bus.mem_we    = mem_we_c;
  assign bus.mem_data  = mem_data_c;

endmodule

// File: tb/tb_fb_host_write_ctrl.sv
// Randomised self-checking bench for fb_host_write_ctrl against a command-level cursor/write model.
module tb_fb_host_write_ctrl;
  localparam int FIFO_DEPTH = 4;
  localparam int COLS       = 40;
  localparam int ROWS       = 30;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  int   exp_q[$];
  int   act_q[$];
  int   illegal = 0;
  int   mx = 0;
  int   my = 0;

  fb_host_write_ctrl_if bus();

  fb_host_write_ctrl #(.FIFO_DEPTH(FIFO_DEPTH), .COLS(COLS), .ROWS(ROWS)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Write monitor: sampled on the falling edge, well away from the active edge.
  always @(negedge clk) begin
    if (!rst && bus.mem_we === 1'b1) begin
      act_q.push_back(int'({bus.mem_addr, bus.mem_data}));
      if (bus.blank !== 1'b1) illegal++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.host_strobe = 1'b0;
    bus.host_data = 8'h00;
    tick(2);
    rst = 1'b0;
    tick(1);
    act_q.delete();
    exp_q.delete();
    illegal = 0;
    mx = 0;
    my = 0;
  endtask

  task automatic model_cmd(input logic [7:0] c);
    int arg;
    arg = int'(c[5:0]);
    case (c[7:6])
      2'd0: mx = (arg > COLS - 1) ? COLS - 1 : arg;
      2'd1: my = (arg > ROWS - 1) ? ROWS - 1 : arg;
      2'd2: begin
        exp_q.push_back(((my * COLS + mx) << 2) | (arg & 3));
`ifdef FBW_AUTOINC_EN
        mx++;
        if (mx == COLS) begin
          mx = 0;
          my++;
          if (my == ROWS) my = 0;
        end
`endif
      end
      default: ;
    endcase
  endtask

  task automatic send(input logic [7:0] b, input bit wait_busy);
    int n;
    n = 0;
    while (wait_busy && bus.host_busy === 1'b1 && n < 3000) begin
      tick(1);
      n++;
    end
    if (n >= 3000) begin
      tests++;
      fails++;
      $display("FAIL send_busy_timeout: host_busy still %0b after %0d cycles, required 0", bus.host_busy, n);
    end
    bus.host_data = b;
    bus.host_strobe = 1'b1;
    tick(4);
    bus.host_strobe = 1'b0;
    tick(4);
  endtask

  task automatic wait_writes(input int n);
    int k;
    k = 0;
    while (act_q.size() < n && k < 8000) begin
      tick(1);
      k++;
    end
    tick(10);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.blank = 1'b1;
    bus.host_strobe = 1'b0;
    bus.host_data = 8'h00;
    tick(2);
    @(negedge clk);
    tests++; if (bus.mem_we !== 1'b0) begin fails++; $display("FAIL reset_mem_we: got %0b want 0", bus.mem_we); end
    tests++; if (bus.host_busy !== 1'b0) begin fails++; $display("FAIL reset_host_busy: got %0b want 0", bus.host_busy); end
    tests++; if (bus.overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow: got %0b want 0", bus.overflow); end
    tests++; if (bus.mem_addr !== 11'd0) begin fails++; $display("FAIL reset_mem_addr: got %0d want 0", bus.mem_addr); end
    do_reset();
  endtask

  task automatic test_pixel_clamp();
    logic [7:0] cmds [6];
    cmds = '{8'h05, 8'h42, 8'h83, 8'h3F, 8'h7F, 8'h81};
    do_reset();
    bus.blank = 1'b1;
    foreach (cmds[i]) begin
      model_cmd(cmds[i]);
      send(cmds[i], 1'b1);
    end
    wait_writes(exp_q.size());
    tests++; if (act_q.size() !== 2) begin fails++; $display("FAIL pixel_count: got %0d want 2", act_q.size()); end
    tests++; if (exp_q[0] !== ((85 << 2) | 3)) begin fails++; $display("FAIL pixel_model_85: got %0d want %0d", exp_q[0], (85 << 2) | 3); end
    tests++; if (exp_q[1] !== ((1199 << 2) | 1)) begin fails++; $display("FAIL pixel_model_1199: got %0d want %0d", exp_q[1], (1199 << 2) | 1); end
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      tests++;
      if (act_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL pixel_write[%0d]: got addr %0d data %0d want addr %0d data %0d", i, act_q[i] >> 2, act_q[i] & 3, exp_q[i] >> 2, exp_q[i] & 3);
      end
    end
  endtask

  task automatic test_blank_hold();
    do_reset();
    bus.blank = 1'b0;
    model_cmd(8'h0A); send(8'h0A, 1'b1);
    model_cmd(8'h44); send(8'h44, 1'b1);
    model_cmd(8'h82); send(8'h82, 1'b1);
    tick(20);
    tests++; if (act_q.size() !== 0) begin fails++; $display("FAIL hold_no_write: got %0d writes want 0", act_q.size()); end
    bus.blank = 1'b1;
    wait_writes(1);
    tests++; if (act_q.size() !== 1) begin fails++; $display("FAIL hold_count: got %0d want 1", act_q.size()); end
    tests++; if (act_q.size() > 0 && act_q[0] !== exp_q[0]) begin fails++; $display("FAIL hold_write: got %0d want %0d", act_q[0], exp_q[0]); end
    tests++; if (illegal !== 0) begin fails++; $display("FAIL hold_illegal: got %0d want 0", illegal); end
  endtask

  task automatic test_overflow();
    logic [7:0] c;
    do_reset();
    bus.blank = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      c = {2'b10, 4'($urandom), 2'(i)};
      model_cmd(c);
      send(c, 1'b0);
      tests++;
      if (bus.host_busy !== ((i + 1) == FIFO_DEPTH)) begin
        fails++;
        $display("FAIL ovf_busy[%0d]: got %0b want %0b", i, bus.host_busy, (i + 1) == FIFO_DEPTH);
      end
    end
    tests++; if (bus.overflow !== 1'b0) begin fails++; $display("FAIL ovf_early: got %0b want 0", bus.overflow); end
    send(8'h83, 1'b0);
    tests++; if (bus.overflow !== 1'b1) begin fails++; $display("FAIL ovf_set: got %0b want 1", bus.overflow); end
    bus.blank = 1'b1;
    wait_writes(FIFO_DEPTH + 1);
    tests++; if (act_q.size() !== FIFO_DEPTH) begin fails++; $display("FAIL ovf_count: got %0d want %0d", act_q.size(), FIFO_DEPTH); end
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      tests++;
      if (act_q[i] !== exp_q[i]) begin fails++; $display("FAIL ovf_write[%0d]: got %0d want %0d", i, act_q[i], exp_q[i]); end
    end
    tests++; if (bus.overflow !== 1'b1 || bus.host_busy !== 1'b0) begin fails++; $display("FAIL ovf_after: overflow %0b busy %0b want 1 0", bus.overflow, bus.host_busy); end
  endtask

  task automatic test_fill();
    int n, bad;
    int seen [COLS*ROWS];
    do_reset();
    bus.blank = 1'b1;
    model_cmd(8'h07); send(8'h07, 1'b1);
    model_cmd(8'h43); send(8'h43, 1'b1);
    send(8'hC2, 1'b1);
    n = 0;
    while (act_q.size() < COLS * ROWS && n < 8000) begin
      tick(1);
      n++;
      if (n % 100 == 0) bus.blank = ~bus.blank;
    end
    bus.blank = 1'b1;
    tick(20);
    tests++; if (act_q.size() !== COLS * ROWS) begin fails++; $display("FAIL fill_count: got %0d want %0d", act_q.size(), COLS * ROWS); end
    foreach (seen[i]) seen[i] = 0;
    bad = 0;
    foreach (act_q[i]) begin
      if ((act_q[i] & 3) != 2 || (act_q[i] >> 2) >= COLS * ROWS) bad++;
      else seen[act_q[i] >> 2]++;
    end
    foreach (seen[i]) if (seen[i] != 1) bad++;
    tests++; if (bad !== 0) begin fails++; $display("FAIL fill_coverage: got %0d bad addresses/data want 0", bad); end
    tests++; if (illegal !== 0) begin fails++; $display("FAIL fill_illegal: got %0d want 0", illegal); end
    act_q.delete();
    model_cmd(8'h81); send(8'h81, 1'b1);
    wait_writes(1);
    tests++; if (act_q.size() !== 1 || act_q[0] !== exp_q[0]) begin fails++; $display("FAIL fill_cursor: got %0d writes first %0d want 1 of %0d", act_q.size(), (act_q.size() > 0) ? act_q[0] : -1, exp_q[0]); end
  endtask

  task automatic test_fill_reset();
    do_reset();
    bus.blank = 1'b1;
    send(8'hC1, 1'b1);
    tick(30);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    act_q.delete();
    tick(40);
    tests++; if (act_q.size() !== 0) begin fails++; $display("FAIL fill_abort: got %0d writes after reset want 0", act_q.size()); end
  endtask

  task automatic test_autoinc();
    do_reset();
    bus.blank = 1'b1;
    model_cmd(8'h27); send(8'h27, 1'b1);
    model_cmd(8'h5D); send(8'h5D, 1'b1);
    model_cmd(8'h82); send(8'h82, 1'b1);
    model_cmd(8'h83); send(8'h83, 1'b1);
    wait_writes(2);
    tests++; if (act_q.size() !== 2) begin fails++; $display("FAIL autoinc_count: got %0d want 2", act_q.size()); end
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      tests++;
      if (act_q[i] !== exp_q[i]) begin fails++; $display("FAIL autoinc_write[%0d]: got %0d want %0d", i, act_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    bit done;
    int errs;
    logic [7:0] c;
    do_reset();
    bus.blank = 1'b1;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          c = {2'($urandom_range(0, 2)), 6'($urandom)};
          model_cmd(c);
          send(c, 1'b1);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          tick($urandom_range(1, 20));
          bus.blank = ~bus.blank;
        end
      end
    join
    bus.blank = 1'b1;
    wait_writes(exp_q.size());
    tests++; if (act_q.size() !== exp_q.size()) begin fails++; $display("FAIL rand_count: got %0d want %0d", act_q.size(), exp_q.size()); end
    errs = 0;
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) if (act_q[i] !== exp_q[i]) errs++;
    tests++; if (errs !== 0) begin fails++; $display("FAIL rand_writes: got %0d mismatching writes want 0", errs); end
    tests++; if (illegal !== 0) begin fails++; $display("FAIL rand_illegal: got %0d want 0", illegal); end
    tests++; if (bus.overflow !== 1'b0) begin fails++; $display("FAIL rand_overflow: got %0b want 0", bus.overflow); end
  endtask

  initial begin
    bus.blank = 1'b1;
    bus.host_strobe = 1'b0;
    bus.host_data = 8'h00;
    test_reset();
    test_pixel_clamp();
    test_blank_hold();
    test_overflow();
    test_fill();
    test_fill_reset();
    test_autoinc();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
